// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: pipeline front-end controller.
// Sequences the PC register, IF/ID and ID/EX pipeline registers through a
// post-reset boot hold, normal running, load-use stalls, taken-branch
// redirects and an externally requested halt. Saturating stall and flush
// event counters are kept for performance debug.
module fetch_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_hazard,
  input  logic             branch_taken_ex,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } stateT;

  // Boot counter is loaded with BOOT_CYCLES-1 so that BOOT lasts exactly
  // BOOT_CYCLES cycles: the exit happens on the cycle the counter reads zero.
  localparam logic [7:0] BOOT_INIT = 8'(BOOT_CYCLES - 1);

  stateT            r_state;
  stateT            w_nextState;
  logic [7:0]       r_bootCnt;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;
  logic             w_stallInc;
  logic             w_flushInc;

  // Next-state and control outputs; reset low overrides everything so the
  // pipeline is held in bubbles while reset is asserted.
  always_comb begin
    w_nextState = r_state;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    w_stallInc  = 1'b0;
    w_flushInc  = 1'b0;

    if (!rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_nextState = BOOT;
    end else begin
      unique case (r_state)
        BOOT: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (r_bootCnt == 8'd0) begin
            w_nextState = RUN;
          end
        end

        RUN: begin
          if (branch_taken_ex) begin
            pc_en       = 1'b1;
            pc_sel      = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_flushInc  = 1'b1;
          end else if (halt_req) begin
            id_ex_flush = 1'b1;
            w_nextState = HALT;
          end else if (load_use_hazard) begin
            id_ex_flush = 1'b1;
            w_stallInc  = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
        end

        HALT: begin
          halted      = 1'b1;
          id_ex_flush = 1'b1;
          if (branch_taken_ex) begin
            pc_en       = 1'b1;
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            w_flushInc  = 1'b1;
          end
          if (!halt_req) begin
            w_nextState = RUN;
          end
        end

        default: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_nextState = BOOT;
        end
      endcase
    end
  end

  // State register and boot hold counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= BOOT;
      r_bootCnt <= BOOT_INIT;
    end else begin
      r_state <= w_nextState;
      if ((r_state == BOOT) && (r_bootCnt != 8'd0)) begin
        r_bootCnt <= r_bootCnt - 8'd1;
      end
    end
  end

  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_stallInc && (r_stallCount != {CNT_W{1'b1}})) begin
        r_stallCount <= r_stallCount + 1'b1;
      end
      if (w_flushInc && (r_flushCount != {CNT_W{1'b1}})) begin
        r_flushCount <= r_flushCount + 1'b1;
      end
    end
  end

  assign stall_count = r_stallCount;
  assign flush_count = r_flushCount;

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Central pipeline controller that sequences the fetch stage and the IF/ID and ID/EX pipeline registers.
- Drives the PC register enable and the redirect select.
- Handles load-use stalls, taken-branch/jump flushes, a post-reset boot hold (instruction memory settle) and an external halt request.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- BOOT_CYCLES, 4, number of cycles fetch is held after reset release; legal range 1..255.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- load_use_hazard  input  1  from decode: instruction in ID depends on a load in EX.
- branch_taken_ex  input  1  from execute: taken branch/jump resolved this cycle.
- halt_req  input  1  external/debug request to freeze fetch; level-sensitive.
- pc_en  output  1  PC register enable (1 = PC loads next value).
- pc_sel  output  1  PC next-value select (1 = target_pc from EX, 0 = PC+4).
- if_id_en  output  1  IF/ID register enable.
- if_id_flush  output  1  IF/ID register loads a NOP bubble.
- id_ex_flush  output  1  ID/EX register loads a NOP bubble.
- halted  output  1  1 while in HALT state.
- stall_count  output  CNT_W  load-use stall cycles since reset, saturating.
- flush_count  output  CNT_W  redirect events since reset, saturating.

Behaviour:
- States: BOOT, RUN, HALT. State, boot counter and both event counters are registered. All control outputs are combinational from state and inputs, so a redirect takes effect in the same cycle.
- Reset (rst=0 at a clock edge):
  - state=BOOT, boot_cnt=BOOT_CYCLES-1, stall_count=0, flush_count=0.
  - While rst=0, outputs are forced: pc_en=0, pc_sel=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, halted=0.
  - Reset asserted mid-operation discards any stall, halt or redirect in progress.
- BOOT:
  - Outputs: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1.
  - boot_cnt decrements each cycle. When boot_cnt==0, go to RUN next cycle. BOOT therefore lasts exactly BOOT_CYCLES cycles after reset release.
  - branch_taken_ex, load_use_hazard and halt_req are ignored in BOOT.
- RUN: priority is redirect > halt > load-use > normal.
  - Redirect (branch_taken_ex=1): pc_en=1, pc_sel=1, if_id_en=1, if_id_flush=1, id_ex_flush=1. The two younger instructions are squashed. flush_count++. A simultaneous load_use_hazard is overridden and not counted.
  - Halt (halt_req=1, no redirect): pc_en=0, if_id_en=0, id_ex_flush=1. Next state HALT.
  - Load-use (load_use_hazard=1, no redirect): pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0. Exactly one bubble per asserted cycle. stall_count++.
  - Normal: pc_en=1, pc_sel=0, if_id_en=1, both flushes 0.
- HALT:
  - halted=1, pc_en=0, if_id_en=0, id_ex_flush=1.
  - A branch_taken_ex in HALT is still honoured (pc_en=1, pc_sel=1, both flushes, flush_count++) and the state stays HALT. This lets an in-flight branch drain.
  - halt_req=0 at a clock edge: next state RUN. Fetch resumes the following cycle.
- Counters:
  - Width CNT_W; hold at all-ones, never wrap.
  - Incremented only on the RUN/HALT conditions above, never in BOOT or during reset.
- pc_sel=0 whenever pc_en=0.
- No X on any output after the first reset edge.

Test Plan:
- Reset for 2 cycles, release, BOOT_CYCLES=4, idle inputs -> pc_en=0 for exactly 4 cycles after release, then pc_en=1, pc_sel=0, both flushes 0.
- In RUN, pulse load_use_hazard 1 cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle pc_en=1; stall_count=1.
- In RUN, assert load_use_hazard and branch_taken_ex together -> pc_en=1, pc_sel=1, if_id_flush=1, id_ex_flush=1; flush_count=1, stall_count unchanged.
- Assert halt_req for 5 cycles with branch_taken_ex pulsed on the 3rd -> halted=1 from the 2nd cycle; redirect outputs on the branch cycle with halted still 1; RUN resumes 1 cycle after halt_req drops.
- CNT_W=3, hold load_use_hazard 10 cycles -> stall_count reaches 7 and stays 7.
- Assert rst=0 mid-halt with counters nonzero -> next cycle state BOOT, counters 0, halted=0, if_id_flush=1.
